// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and EX/MEM training bus of the branch target predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_target_predictor_if #(
  parameter int PC_WIDTH = 32,
  parameter int PERF_W   = 32
);
  logic [PC_WIDTH-1:0] pc_if;
  logic                pred_hit;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_next_pc;
  logic                upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic                upd_taken;
  logic [PC_WIDTH-1:0] upd_target;
  logic                upd_is_jump;
  logic                upd_mispredict;
  logic                inv_all;
  logic [PERF_W-1:0]   perf_mispred;

  modport master (
    output pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_mispredict, inv_all,
    input  pred_hit, pred_taken, pred_next_pc, perf_mispred
  );

  modport slave (
    input  pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_mispredict, inv_all,
    output pred_hit, pred_taken, pred_next_pc, perf_mispred
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and a saturating
// misprediction counter. Lookup is combinational; training lands on the next edge.

module btb_entry #(
  parameter int PC_WIDTH = 32,
  parameter int TAG_W    = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inv,
  input  logic                sel,
  input  logic [TAG_W-1:0]    upd_tag,
  input  logic                upd_taken,
  input  logic                upd_is_jump,
  input  logic [PC_WIDTH-1:0] upd_target,
  output logic                valid,
  output logic [TAG_W-1:0]    tag,
  output logic [PC_WIDTH-1:0] target,
  output logic [1:0]          ctr
);
  logic hit;
  assign hit = valid && (tag == upd_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'b01;
    end else if (inv) begin
      // flush wins over any training presented in the same cycle
      valid <= 1'b0;
    end else if (sel) begin
      if (hit) begin
        if (upd_is_jump)    ctr <= 2'b11;
        else if (upd_taken) ctr <= (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else                ctr <= (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        if (upd_taken) target <= upd_target;
      end else if (upd_taken) begin
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        ctr    <= upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end
endmodule

module branch_target_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int ENTRIES  = 16,
  parameter int PERF_W   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  branch_target_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic [ENTRIES-1:0]               valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]    tag_q;
  logic [ENTRIES-1:0][PC_WIDTH-1:0] target_q;
  logic [ENTRIES-1:0][1:0]          ctr_q;
  logic [ENTRIES-1:0]               wr_sel;

  logic [IDX_W-1:0] pc_idx, upd_idx;
  logic [TAG_W-1:0] pc_tag, upd_tag;
  logic [PERF_W-1:0] perf_q;
  logic unused_bits;

  assign pc_idx  = bus.pc_if[IDX_W+1:2];
  assign pc_tag  = bus.pc_if[PC_WIDTH-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[PC_WIDTH-1:IDX_W+2];
  assign unused_bits = ^{bus.pc_if[1:0], bus.upd_pc[1:0]};

  assign wr_sel = bus.upd_valid ? (ENTRIES'(1) << upd_idx) : '0;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    btb_entry #(.PC_WIDTH(PC_WIDTH), .TAG_W(TAG_W)) u_ent (
      .clk         (clk),
      .rst_n       (rst_n),
      .inv         (bus.inv_all),
      .sel         (wr_sel[e]),
      .upd_tag     (upd_tag),
      .upd_taken   (bus.upd_taken),
      .upd_is_jump (bus.upd_is_jump),
      .upd_target  (bus.upd_target),
      .valid       (valid_q[e]),
      .tag         (tag_q[e]),
      .target      (target_q[e]),
      .ctr         (ctr_q[e])
    );
  end

  // Lookup reads registered state only: same-cycle training is not bypassed.
  always_comb begin
    bus.pred_hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    bus.pred_taken   = bus.pred_hit && ctr_q[pc_idx][1];
    bus.pred_next_pc = bus.pred_taken ? target_q[pc_idx] : bus.pc_if + PC_WIDTH'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_q <= '0;
    else if (bus.upd_valid && bus.upd_mispredict && !(&perf_q))
      perf_q <= perf_q + PERF_W'(1);
  end
  assign bus.perf_mispred = perf_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: default instance plus a PERF_W=2
// instance for counter saturation.
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_target_predictor_if #(.PC_WIDTH(32), .PERF_W(32)) a();
  branch_target_predictor_if #(.PC_WIDTH(32), .PERF_W(2))  b();

  branch_target_predictor #(.PC_WIDTH(32), .ENTRIES(16), .PERF_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a));
  branch_target_predictor #(.PC_WIDTH(32), .ENTRIES(16), .PERF_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic jmp);
    a.upd_valid = 1'b1; a.upd_pc = pc; a.upd_taken = tk; a.upd_target = tgt;
    a.upd_is_jump = jmp;
    tick();
    a.upd_valid = 1'b0; a.upd_is_jump = 1'b0; a.upd_mispredict = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] nxt);
    a.pc_if = pc; #1;
    checks++;
    if (a.pred_hit !== hit || a.pred_taken !== tk || a.pred_next_pc !== nxt) begin
      errors++;
      $display("FAIL %s: got hit=%b taken=%b next=%h, want hit=%b taken=%b next=%h",
               nm, a.pred_hit, a.pred_taken, a.pred_next_pc, hit, tk, nxt);
    end
  endtask

  task automatic test_reset();
    a.pc_if = 32'h40; #1;
    checks++;
    if (a.pred_hit !== 1'b0 || a.pred_next_pc !== 32'h44) begin
      errors++; $display("FAIL reset_held: hit=%b next=%h want 0/00000044", a.pred_hit, a.pred_next_pc);
    end
    #12 rst_n = 1'b1;
    tick();
    look("reset_release", 32'h40, 1'b0, 1'b0, 32'h44);
    checks++;
    if (a.perf_mispred !== 32'd0 || b.perf_mispred !== 2'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", a.perf_mispred, b.perf_mispred);
    end
  endtask

  task automatic test_alloc();
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("alloc_hit", 32'h40, 1'b1, 1'b1, 32'h100);
    look("alias_miss", 32'h80, 1'b0, 1'b0, 32'h84);
    upd(32'h80, 1'b0, 32'h900, 1'b0);
    look("nt_miss_no_alloc", 32'h80, 1'b0, 1'b0, 32'h84);
    look("nt_miss_keeps_old", 32'h40, 1'b1, 1'b1, 32'h100);
  endtask

  task automatic test_decay();
    upd(32'h40, 1'b0, 32'h500, 1'b0);
    look("decay_weak_nt", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h500, 1'b0);
    look("decay_strong_nt", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h500, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("recover_one", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("recover_taken", 32'h40, 1'b1, 1'b1, 32'h100);
  endtask

  task automatic test_jump_flush();
    upd(32'h200, 1'b1, 32'h20, 1'b1);
    look("jump_alloc", 32'h200, 1'b1, 1'b1, 32'h20);
    // one not-taken update leaves a strong-taken entry still predicting taken
    upd(32'h200, 1'b0, 32'h0, 1'b0);
    look("jump_strong", 32'h200, 1'b1, 1'b1, 32'h20);
    a.inv_all = 1'b1;
    upd(32'h300, 1'b1, 32'h340, 1'b0);
    a.inv_all = 1'b0;
    look("flush_old", 32'h200, 1'b0, 1'b0, 32'h204);
    look("flush_upd_dropped", 32'h300, 1'b0, 1'b0, 32'h304);
  endtask

  task automatic test_same_cycle();
    a.pc_if = 32'h40;
    a.upd_valid = 1'b1; a.upd_pc = 32'h40; a.upd_taken = 1'b1;
    a.upd_target = 32'h180; a.upd_is_jump = 1'b0;
    look("same_cycle_old", 32'h40, 1'b0, 1'b0, 32'h44);
    tick();
    a.upd_valid = 1'b0;
    look("same_cycle_next", 32'h40, 1'b1, 1'b1, 32'h180);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_perf();
    a.upd_mispredict = 1'b1; upd(32'h40, 1'b0, 32'h0, 1'b0);
    a.upd_mispredict = 1'b1; a.inv_all = 1'b1; upd(32'h40, 1'b0, 32'h0, 1'b0);
    a.inv_all = 1'b0;
    a.upd_mispredict = 1'b1; upd(32'h40, 1'b0, 32'h0, 1'b0);
    checks++;
    if (a.perf_mispred !== 32'd3) begin
      errors++; $display("FAIL perf_count: got %0d want 3", a.perf_mispred);
    end
    a.upd_mispredict = 1'b1; tick(); a.upd_mispredict = 1'b0;
    checks++;
    if (a.perf_mispred !== 32'd3) begin
      errors++; $display("FAIL perf_unqualified: got %0d want 3", a.perf_mispred);
    end
    b.upd_valid = 1'b1; b.upd_mispredict = 1'b1;
    tick(); tick();
    checks++;
    if (b.perf_mispred !== 2'd2) begin
      errors++; $display("FAIL perf_small: got %0d want 2", b.perf_mispred);
    end
    tick(); tick(); tick();
    b.upd_valid = 1'b0; b.upd_mispredict = 1'b0;
    checks++;
    if (b.perf_mispred !== 2'd3) begin
      errors++; $display("FAIL perf_saturate: got %0d want 3", b.perf_mispred);
    end
  endtask

  task automatic test_reset_mid();
    a.upd_valid = 1'b1; a.upd_pc = 32'h7C; a.upd_taken = 1'b1;
    a.upd_target = 32'h500; a.upd_is_jump = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    a.upd_valid = 1'b0; a.upd_is_jump = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    look("reset_mid_lost", 32'h7C, 1'b0, 1'b0, 32'h80);
    look("reset_mid_table", 32'h40, 1'b0, 1'b0, 32'h44);
    checks++;
    if (a.perf_mispred !== 32'd0 || b.perf_mispred !== 2'd0) begin
      errors++; $display("FAIL reset_mid_perf: got %0d/%0d want 0/0", a.perf_mispred, b.perf_mispred);
    end
  endtask

  initial begin
    a.pc_if = '0; a.upd_valid = 1'b0; a.upd_pc = '0; a.upd_taken = 1'b0;
    a.upd_target = '0; a.upd_is_jump = 1'b0; a.upd_mispredict = 1'b0; a.inv_all = 1'b0;
    b.pc_if = '0; b.upd_valid = 1'b0; b.upd_pc = '0; b.upd_taken = 1'b0;
    b.upd_target = '0; b.upd_is_jump = 1'b0; b.upd_mispredict = 1'b0; b.inv_all = 1'b0;
    test_reset();
    test_alloc();
    test_decay();
    test_jump_flush();
    test_same_cycle();
    test_perf();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
